// File: rtl/block_stream_arbiter_if.sv
`timescale 1ns/1ps
// Stream-side bundle between the ROMix core array, the word mux and the write port.
// master = arbiter side, slave = core array / mux / downstream side.
interface block_stream_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int REQ_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic [REQ_W-1:0]      src_sel;
  logic [4:0]            sel;
  logic [DATA_WIDTH-1:0] mux_out;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [NUM_REQ-1:0]    done;

  modport master (
    input  req, mux_out, out_ready,
    output gnt, src_sel, sel, out_data, out_valid, out_last, done
  );

  modport slave (
    output req, mux_out, out_ready,
    input  gnt, src_sel, sel, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/block_stream_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter streaming one core's 32-word block through a shared word mux; grant 1 cycle after req, 34 cycles/block.
// Backpressure: while out_valid && !out_ready the word index, data and last flag hold.
module block_stream_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  block_stream_arbiter_if.master      bus
);
  localparam int         REQ_W     = $clog2(NUM_REQ);
  localparam logic [4:0] LAST_WORD = 5'd31;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t           state_q, state_d;
  logic [REQ_W-1:0] src_q, src_d;
  logic [REQ_W-1:0] ptr_q, ptr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [REQ_W-1:0] win;
  logic             found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      ptr_q   <= REQ_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    found         = 1'b0;
    win           = ptr_q;
    bus.gnt       = '0;
    bus.done      = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;

    // First requester strictly after the last winner, wrapping round.
    for (int i = 1; i <= NUM_REQ; i++) begin
      logic [REQ_W-1:0] cand;
      cand = REQ_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          src_d   = win;
          ptr_d   = win;
          state_d = STREAM;
        end
      end
      STREAM: begin
        bus.gnt[src_q] = 1'b1;
        bus.out_valid  = 1'b1;
        bus.out_last   = (cnt_q == LAST_WORD);
        // cnt parks at 31 on the final beat; DONE returns it to 0.
        if (bus.out_ready) begin
          if (cnt_q == LAST_WORD) state_d = DONE;
          else                    cnt_d   = cnt_q + 5'd1;
        end
      end
      DONE: begin
        bus.done[src_q] = 1'b1;
        cnt_d           = '0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.src_sel  = src_q;
  assign bus.sel      = cnt_q;
  assign bus.out_data = bus.mux_out;
endmodule

// File: tb/tb_block_stream_arbiter.sv
`timescale 1ns/1ps
// Randomised scoreboard bench: a transfer-level round-robin model predicts grant order and
// block contents; a negedge monitor checks every cycle of the stream against that queue.
module tb_block_stream_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  typedef logic [31:0][DW-1:0] blk_t;
  typedef struct packed {
    blk_t words;
    int   core;
    bit   first;
    int   req_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_stream_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

  block_stream_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Each core's current block, presented through the behavioural word mux.
  blk_t cur_blk[NR];
  assign bus.mux_out = cur_blk[bus.src_sel][bus.sel];

  exp_t expq[$];
  blk_t blkq[NR][$];
  int   pending[NR];
  bit   dropped[NR];
  int   model_ptr;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int c);
    return NR'(1) << c;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b = '0;
    for (int i = 0; i < 32; i++) b = {b[30:0], 32'($urandom)};
    return b;
  endfunction

  function automatic int next_winner(input int ptr, input int cnt[NR]);
    for (int k = 1; k <= NR; k++) begin
      int c = (ptr + k) % NR;
      if (cnt[c] > 0) return c;
    end
    return -1;
  endfunction

  // Predict the whole grant sequence for the currently pending work.
  task automatic plan();
    int mc[NR];
    int used[NR];
    bit first = 1'b1;
    int w;
    for (int c = 0; c < NR; c++) begin
      mc[c]   = pending[c];
      used[c] = 0;
    end
    w = next_winner(model_ptr, mc);
    while (w >= 0) begin
      blk_t b = (used[w] == 0) ? cur_blk[w] : blkq[w][used[w]-1];
      expq.push_back('{words: b, core: w, first: first, req_cyc: cyc});
      used[w]++;
      mc[w]--;
      model_ptr = w;
      first     = 1'b0;
      w         = next_winner(model_ptr, mc);
    end
  endtask

  function automatic bit busy();
    for (int c = 0; c < NR; c++) if (pending[c] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Cores: hold req until done, swap in the next block after each done.
  task automatic drive(input int mode, input bit drop);
    int ph = 0;
    for (int t = 0; t < 6000 && busy(); t++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NR; c++) begin
        if (bus.done[c]) begin
          pending[c]--;
          dropped[c] = 1'b0;
          if (pending[c] > 0) cur_blk[c] = blkq[c].pop_front();
        end
      end
      if (drop && bus.gnt != '0 && bus.sel == 5'd10 && pending[bus.src_sel] == 1)
        dropped[bus.src_sel] = 1'b1;
      for (int c = 0; c < NR; c++) bus.req[c] = (pending[c] > 0) && !dropped[c];
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (ph % 3 == 0);
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      ph++;
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    int cnt[NR];
    cnt = '{c0, c1, c2, c3};
    for (int c = 0; c < NR; c++) begin
      for (int k = 0; k < cnt[c]; k++) blkq[c].push_back(rand_blk());
      pending[c] = cnt[c];
      dropped[c] = 1'b0;
      if (cnt[c] > 0) cur_blk[c] = blkq[c].pop_front();
    end
    plan();
    for (int c = 0; c < NR; c++) bus.req[c] = pending[c] > 0;
  endtask

  task automatic run_round(input int c0, input int c1, input int c2, input int c3,
                           input int mode, input bit drop);
    load(c0, c1, c2, c3);
    drive(mode, drop);
  endtask

  // Cores 0 and 1 request; reset lands while word 15 is on the bus.
  task automatic reset_phase();
    load(1, 1, 0, 0);
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      if (bus.out_valid && bus.sel == 5'd15) break;
    end
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    model_ptr = NR - 1;
    expq.delete();
    plan();
    drive(0, 1'b0);
  endtask

  initial begin : monitor
    bit   active, exp_done, hold, have_prev, rst_prev, prog;
    exp_t cur;
    int   w, stalls, prev_start, prev_stalls, done_core, idle;
    logic [4:0]    w5;
    logic [DW-1:0] p_data;
    logic [4:0]    p_sel;
    logic          p_last;
    active = 0; exp_done = 0; hold = 0; have_prev = 0; rst_prev = 1;
    w = 0; stalls = 0; prev_start = 0; prev_stalls = 0; done_core = 0; idle = 0;
    cur = '0; p_data = '0; p_sel = '0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      prog = 1'b0;
      if (!rst_n) begin
        if (!rst_prev) begin
          chk("rst_gnt", bus.gnt, 0);
          chk("rst_src_sel", bus.src_sel, 0);
          chk("rst_sel", bus.sel, 0);
          chk("rst_valid", bus.out_valid, 0);
          chk("rst_last", bus.out_last, 0);
          chk("rst_done", bus.done, 0);
          active = 0; exp_done = 0; hold = 0; have_prev = 0;
        end
        rst_prev = 1'b0;
        idle     = 0;
      end else begin
        rst_prev = 1'b1;
        if (exp_done) begin
          chk("done_pulse", bus.done, onehot(done_core));
          chk("done_gnt", bus.gnt, 0);
          exp_done = 1'b0;
        end else begin
          chk("done_quiet", bus.done, 0);
        end
        if (hold) begin
          chk("hold_data", bus.out_data, p_data);
          chk("hold_sel", bus.sel, p_sel);
          chk("hold_last", bus.out_last, p_last);
        end
        if (!active && bus.gnt != '0) begin
          if (expq.size() == 0) begin
            chk("unexpected_gnt", bus.gnt, 0);
          end else begin
            cur = expq.pop_front();
            chk("gnt", bus.gnt, onehot(cur.core));
            chk("src_sel", bus.src_sel, cur.core);
            if (cur.first)    chk("req_to_gnt", cyc - cur.req_cyc, 1);
            else if (have_prev) chk("block_period", cyc - prev_start, 34 + prev_stalls);
            prev_start = cyc;
            active = 1'b1; w = 0; stalls = 0; prog = 1'b1;
          end
        end
        if (active) begin
          w5 = w[4:0];
          chk("valid", bus.out_valid, 1);
          chk("sel", bus.sel, w);
          chk("last", bus.out_last, (w == 31));
          chk("data", bus.out_data, cur.words[w5]);
          if (bus.out_ready) begin
            w++;
            prog = 1'b1;
            if (w == 32) begin
              active = 1'b0; exp_done = 1'b1; done_core = cur.core;
              prev_stalls = stalls; have_prev = 1'b1;
            end
          end else begin
            stalls++;
          end
        end else begin
          chk("valid_idle", bus.out_valid, 0);
        end
        hold   = bus.out_valid && !bus.out_ready;
        p_data = bus.out_data;
        p_sel  = bus.sel;
        p_last = bus.out_last;
        if (prog) idle = 0;
        else if (active || exp_done || expq.size() != 0) begin
          idle++;
          if (idle >= 300) begin
            chk("progress_watchdog", idle, 0);
            idle = 0;
          end
        end
      end
    end
  end

  initial begin : stim
    int m;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    model_ptr     = NR - 1;
    for (int c = 0; c < NR; c++) begin
      pending[c] = 0;
      dropped[c] = 1'b0;
      cur_blk[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_round(1, 1, 1, 1, 0, 1'b0);   // contention: 0,1,2,3
    run_round(0, 1, 0, 0, 0, 1'b0);   // ptr=3, core 1 alone
    run_round(0, 0, 1, 0, 0, 1'b0);   // single request, no backpressure
    run_round(3, 0, 3, 0, 1, 1'b0);   // fairness under 1,0,0 ready pattern
    run_round(0, 0, 0, 1, 0, 1'b1);   // core 3 drops req at word 10
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(1, 15);
      run_round(m[0] ? $urandom_range(1, 3) : 0, m[1] ? $urandom_range(1, 3) : 0,
                m[2] ? $urandom_range(1, 3) : 0, m[3] ? $urandom_range(1, 3) : 0,
                2, bit'($urandom_range(0, 1)));
    end
    run_round(0, 0, 1, 0, 2, 1'b0);
    reset_phase();
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/block_stream_arbiter.md
# block_stream_arbiter

Shares one 32:1 word mux and one downstream 32-bit write port among NUM_REQ ROMix cores. Each core holds a 1024-bit scrypt block (32 × 32-bit words).
- Round-robin arbitration selects one core; the block drives that core's index to the external block-select mux and steps the 32:1 word-select.
- The selected core's 32 words stream out in order 0..31 under valid/ready handshake.
- A one-cycle done pulse returns to the granted core.
- Sits between the ROMix core array and the scratchpad/output write port.

## Interface
- DATA_WIDTH, 32, word width; must match the word mux.
- NUM_REQ, 4, number of requesting cores; legal range 2..16.
- REQ_W, $clog2(NUM_REQ), width of src_sel (derived localparam).

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  per-core request. Held high by the core until its done pulse.
- gnt  out  NUM_REQ  one-hot grant. Held for the whole transfer.
- src_sel  out  REQ_W  index of the granted core; selects which core's 32 words feed the word mux.
- sel  out  5  word index driven to the 32:1 word mux.
- mux_out  in  DATA_WIDTH  combinational output of the word mux.
- out_data  out  DATA_WIDTH  stream word; combinational pass-through of mux_out.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with word 31.
- done  out  NUM_REQ  one-hot, one-cycle pulse after the last word of that core's transfer.

## Operation
- State machine: IDLE, STREAM, DONE.
- IDLE:
  - gnt=0, out_valid=0, sel=0.
  - If |req: select the winner by round-robin, searching upward (with wrap) from index ptr+1, where ptr is the last granted core (ptr=NUM_REQ-1 after reset, so core 0 has first priority).
  - Register gnt=onehot(winner), src_sel=winner, ptr=winner, cnt=0; go to STREAM.
- STREAM:
  - out_valid=1, sel=cnt, out_last=(cnt==31).
  - Beat = out_valid && out_ready. On a beat, cnt increments (5-bit). On a beat with cnt==31, go to DONE.
  - No beat: cnt, sel and src_sel hold. out_data follows mux_out, so the granted core must hold its block stable while gnt is high.
- DONE:
  - done[src_sel]=1 for exactly one cycle; gnt is cleared in this cycle; out_valid=0.
  - Next state IDLE.
- req deasserted mid-transfer: ignored; the transfer completes and done still pulses.
- req sampled in DONE: ignored; arbitration occurs only in IDLE.
- Word count is fixed at 32. cnt never exceeds 31 and wraps to 0 only through IDLE.
- src_sel and ptr hold their values in IDLE; only gnt indicates ownership.

## Timing
- Reset (rst_n low at a rising edge), next cycle:
  - state=IDLE, gnt=0, src_sel=0, sel=0, cnt=0, out_valid=0, out_last=0, done=0, ptr=NUM_REQ-1.
- Reset mid-STREAM aborts the transfer with no done pulse. The aborted core keeps req high and is re-arbitrated normally.
- Latency:
  - req high in IDLE at edge N → gnt, src_sel and out_valid high from edge N+1; word 0 is presented in cycle N+1.
  - With out_ready held at 1, words 0..31 occupy 32 consecutive cycles.
  - done pulses in the cycle after word 31; IDLE follows.
  - Back-to-back transfers cost 34 cycles per block: 32 STREAM + 1 DONE + 1 IDLE.
- Handshake:
  - out_valid, once high, stays high until word 31 is accepted.
  - out_data, sel and out_last stay stable while out_valid && !out_ready.
- Outputs gnt, src_sel, sel, out_valid, out_last and done are decoded from registered state only; none depends combinationally on req or out_ready.

## Test plan
- Single request, no backpressure: req=4'b0100 from reset, out_ready=1, mux model returns {src,word} → gnt=4'b0100 one cycle later; 32 beats with sel 0..31; out_last only on beat 31; done=4'b0100 for 1 cycle; then IDLE.
- Backpressure: out_ready toggles 1,0,0,1,... → sel, out_data and out_last frozen while ready=0; exactly 32 accepted words in order; no word duplicated or skipped.
- Contention: req=4'b1111 held, each core dropping req after its done → grant order 0,1,2,3; then core 1 re-requested with ptr=3 → core 1 granted; 34-cycle period per block.
- Fairness: cores 0 and 2 request continuously → grants alternate 0,2,0,2,...; core 0 never wins twice in a row.
- Request drop: core 3 drops req at word 10 → transfer completes through word 31 and done[3] pulses.
- Reset mid-transfer: rst_n low at word 15 → next cycle all outputs at reset values with no done pulse; core 0 re-granted from word 0 after rst_n high.
